ip_sequencer: RTL and testbench

Parametrised instruction-pointer sequencer for the MiniAlu-class cores. It generates the fetch address, applies branch, call and return redirects with zero-bubble bypass, and holds return addresses in a hardware stack of configurable depth. It replaces the counter-plus-single-return-register scheme, which supports only one call level. It sits between the core's execute-stage control decode and the instruction ROM address input.

---
 rtl/ip_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_ip_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ip_sequencer.sv
// ip_sequencer: instruction-pointer sequencer with a hardware return stack.
//
// Produces the instruction fetch address. Branch, call and return redirects
// reach oIP combinationally, so the redirected instruction is fetched in the
// same cycle with no bubble. Return addresses are kept in a register-array
// stack that is STACK_DEPTH entries deep.
//
// Optional build macro: IPSEQ_TRAP_EN
//   When it is defined, a stack overflow or underflow redirects fetch to
//   TRAP_VECTOR and pulses oTrap for that cycle.
//   When it is undefined, TRAP_VECTOR is unused and oTrap does not exist.
//
// Ports:
//   Clock           system clock; all state changes on posedge
//   Reset           asynchronous, active-low reset
//   iEnable         1 = advance, 0 = stall (all control inputs are ignored)
//   iBranchTaken    redirect to iTarget
//   iCall           redirect to iTarget and push the return address
//   iRet            redirect to the popped return address
//   iTarget         branch/call destination
//   iClearFlags     clears the sticky fault flags
//   oIP             current fetch address (redirect bypassed)
//   oStackDepth     number of valid stack entries
//   oStackEmpty     oStackDepth == 0
//   oStackFull      oStackDepth == STACK_DEPTH
//   oStackOverflow  sticky: a call was attempted while the stack was full
//   oStackUnderflow sticky: a return was attempted while the stack was empty
//   oTrap           (IPSEQ_TRAP_EN only) high in the cycle of a stack fault
module ip_sequencer #(
    parameter int                    ADDR_WIDTH   = 16,
    parameter int                    STACK_DEPTH  = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = {ADDR_WIDTH{1'b0}},
    parameter logic [ADDR_WIDTH-1:0] TRAP_VECTOR  = 16'hFFF0
) (
    input  logic                             Clock,
    input  logic                             Reset,
    input  logic                             iEnable,
    input  logic                             iBranchTaken,
    input  logic                             iCall,
    input  logic                             iRet,
    input  logic [ADDR_WIDTH-1:0]            iTarget,
    input  logic                             iClearFlags,
    output logic [ADDR_WIDTH-1:0]            oIP,
    output logic [$clog2(STACK_DEPTH+1)-1:0] oStackDepth,
    output logic                             oStackEmpty,
    output logic                             oStackFull,
    output logic                             oStackOverflow,
    output logic                             oStackUnderflow
`ifdef IPSEQ_TRAP_EN
    ,
    output logic                             oTrap
`endif
);

    localparam int DW = $clog2(STACK_DEPTH + 1);

    logic [ADDR_WIDTH-1:0] rIP;
    logic [DW-1:0]         rDepth;
    logic [ADDR_WIDTH-1:0] rStack [STACK_DEPTH];
    logic                  rOverflow;
    logic                  rUnderflow;

    logic                  doRet;
    logic                  doCall;
    logic                  doBranch;
    logic                  stackEmpty;
    logic                  stackFull;
    logic                  overflowEvt;
    logic                  underflowEvt;
    logic [ADDR_WIDTH-1:0] topEntry;
    logic [ADDR_WIDTH-1:0] ipSel;
`ifdef IPSEQ_TRAP_EN
    logic                  trapHit;
`endif

    assign stackEmpty   = (rDepth == DW'(0));
    assign stackFull    = (rDepth == DW'(STACK_DEPTH));
    assign overflowEvt  = doCall & stackFull;
    assign underflowEvt = doRet & stackEmpty;

    // Redirect select: ret beats call, and call beats branch. A stall masks every request.
    always_comb begin
        doRet    = 1'b0;
        doCall   = 1'b0;
        doBranch = 1'b0;
        if (iEnable) begin
            doRet    = iRet;
            doCall   = iCall & ~iRet;
            doBranch = iBranchTaken & ~iRet & ~iCall;
        end else begin
            doRet    = 1'b0;
            doCall   = 1'b0;
            doBranch = 1'b0;
        end
    end

    // Top-of-stack read is entry[depth-1]. An empty stack matches no entry,
    // so the result falls through to RESET_VECTOR, which is the empty-return target.
    always_comb begin
        topEntry = RESET_VECTOR;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (rDepth == DW'(i + 1)) begin
                topEntry = rStack[i];
            end else begin
                topEntry = topEntry;
            end
        end
    end

    // Fetch address: the redirect target when a redirect is taken, otherwise the running IP.
    always_comb begin
        ipSel = rIP;
        if (doRet) begin
            ipSel = topEntry;
        end else if (doCall || doBranch) begin
            ipSel = iTarget;
        end else begin
            ipSel = rIP;
        end
`ifdef IPSEQ_TRAP_EN
        trapHit = 1'b0;
        if (overflowEvt || underflowEvt) begin
            ipSel   = TRAP_VECTOR;
            trapHit = 1'b1;
        end else begin
            trapHit = 1'b0;
        end
`endif
    end

    assign oIP = ipSel;
`ifdef IPSEQ_TRAP_EN
    assign oTrap = trapHit;
`endif

    // Instruction pointer: the successor of whatever was fetched this cycle, wrapping modulo 2^ADDR_WIDTH.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            rIP <= RESET_VECTOR;
        end else if (iEnable) begin
            rIP <= ipSel + ADDR_WIDTH'(1);
        end else begin
            rIP <= rIP;
        end
    end

    // Stack depth: saturates at both ends. A dropped push or pop leaves it unchanged.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            rDepth <= DW'(0);
        end else if (doCall && !stackFull) begin
            rDepth <= rDepth + DW'(1);
        end else if (doRet && !stackEmpty) begin
            rDepth <= rDepth - DW'(1);
        end else begin
            rDepth <= rDepth;
        end
    end

    // Stack storage: a push writes entry[depth] with the pre-update rIP, which is the caller's successor.
    always_ff @(posedge Clock) begin
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (doCall && !stackFull && (rDepth == DW'(i))) begin
                rStack[i] <= rIP;
            end else begin
                rStack[i] <= rStack[i];
            end
        end
    end

    // Sticky fault flags: a set event beats a clear in the same cycle. A stall freezes both flags.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            rOverflow  <= 1'b0;
            rUnderflow <= 1'b0;
        end else begin
            if (overflowEvt) begin
                rOverflow <= 1'b1;
            end else if (iEnable && iClearFlags) begin
                rOverflow <= 1'b0;
            end else begin
                rOverflow <= rOverflow;
            end
            if (underflowEvt) begin
                rUnderflow <= 1'b1;
            end else if (iEnable && iClearFlags) begin
                rUnderflow <= 1'b0;
            end else begin
                rUnderflow <= rUnderflow;
            end
        end
    end

    assign oStackDepth     = rDepth;
    assign oStackEmpty     = stackEmpty;
    assign oStackFull      = stackFull;
    assign oStackOverflow  = rOverflow;
    assign oStackUnderflow = rUnderflow;

endmodule

// File: tb/tb_ip_sequencer.sv
// tb_ip_sequencer: scoreboard bench for ip_sequencer, configured with STACK_DEPTH = 4.
// Each step drives the inputs, computes the expected outputs from a
// queue-based stack model, pushes them to a queue, and compares them at the negedge.
module tb_ip_sequencer;

    localparam int AW = 16;
    localparam int SD = 4;
    localparam int DW = $clog2(SD + 1);
    localparam logic [AW-1:0] RV = 16'h0000;
    localparam logic [AW-1:0] TV = 16'hFFF0;

    logic          Clock = 1'b0;
    logic          Reset;
    logic          iEnable, iBranchTaken, iCall, iRet, iClearFlags;
    logic [AW-1:0] iTarget;
    logic [AW-1:0] oIP;
    logic [DW-1:0] oStackDepth;
    logic          oStackEmpty, oStackFull, oStackOverflow, oStackUnderflow;
    logic          oTrap;

    ip_sequencer #(
        .ADDR_WIDTH(AW), .STACK_DEPTH(SD), .RESET_VECTOR(RV), .TRAP_VECTOR(TV)
    ) dut (
        .Clock(Clock), .Reset(Reset), .iEnable(iEnable),
        .iBranchTaken(iBranchTaken), .iCall(iCall), .iRet(iRet),
        .iTarget(iTarget), .iClearFlags(iClearFlags), .oIP(oIP),
        .oStackDepth(oStackDepth), .oStackEmpty(oStackEmpty),
        .oStackFull(oStackFull), .oStackOverflow(oStackOverflow),
        .oStackUnderflow(oStackUnderflow)
`ifdef IPSEQ_TRAP_EN
        , .oTrap(oTrap)
`endif
    );

`ifndef IPSEQ_TRAP_EN
    assign oTrap = 1'b0;
`endif

    always #5 Clock = ~Clock;

    typedef struct {
        logic [AW-1:0] ip;
        logic [DW-1:0] depth;
        logic          empty, full, ovf, unf, trap;
    } exp_t;

    exp_t          expQ [$];
    logic [AW-1:0] mStack [$];
    logic [AW-1:0] mIP;
    logic          mOvf, mUnf;
    int            nVectors = 0;
    int            nMiscompares = 0;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nVectors++;
        if (obs !== expv) begin
            nMiscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic modelReset();
        mStack.delete();
        mIP  = RV;
        mOvf = 1'b0;
        mUnf = 1'b0;
    endtask

    // Entered at posedge+1. Drive the inputs, queue the expectation, compare at negedge, then advance the model.
    task automatic step(input logic en, input logic br, input logic call, input logic ret,
                        input logic [AW-1:0] tgt, input logic clr);
        exp_t e, got;
        logic ovfEvt, unfEvt;
        iEnable = en; iBranchTaken = br; iCall = call; iRet = ret;
        iTarget = tgt; iClearFlags = clr;
        ovfEvt  = 1'b0;
        unfEvt  = 1'b0;
        e.ip    = mIP;
        e.trap  = 1'b0;
        e.depth = DW'(mStack.size());
        e.empty = (mStack.size() == 0);
        e.full  = (mStack.size() == SD);
        e.ovf   = mOvf;
        e.unf   = mUnf;
        if (en) begin
            if (ret) begin
                if (mStack.size() == 0) begin
                    e.ip = RV; unfEvt = 1'b1;
                end else begin
                    e.ip = mStack[mStack.size() - 1];
                end
            end else if (call) begin
                e.ip = tgt;
                ovfEvt = (mStack.size() == SD);
            end else if (br) begin
                e.ip = tgt;
            end
`ifdef IPSEQ_TRAP_EN
            if (ovfEvt || unfEvt) begin
                e.ip = TV; e.trap = 1'b1;
            end
`endif
        end
        expQ.push_back(e);
        @(negedge Clock);
        got = expQ.pop_front();
        checkVal("oIP",        32'(oIP),             32'(got.ip));
        checkVal("depth",      32'(oStackDepth),     32'(got.depth));
        checkVal("empty",      32'(oStackEmpty),     32'(got.empty));
        checkVal("full",       32'(oStackFull),      32'(got.full));
        checkVal("overflow",   32'(oStackOverflow),  32'(got.ovf));
        checkVal("underflow",  32'(oStackUnderflow), 32'(got.unf));
        checkVal("trap",       32'(oTrap),           32'(got.trap));
        if (en) begin
            if (ret) begin
                if (mStack.size() > 0) void'(mStack.pop_back());
            end else if (call && mStack.size() < SD) begin
                mStack.push_back(mIP);
            end
            mIP = got.ip + 16'h0001;
            if (ovfEvt) mOvf = 1'b1; else if (clr) mOvf = 1'b0;
            if (unfEvt) mUnf = 1'b1; else if (clr) mUnf = 1'b0;
        end
        @(posedge Clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    endtask

    initial begin
        Reset = 1'b0; iEnable = 1'b0; iBranchTaken = 1'b0; iCall = 1'b0;
        iRet = 1'b0; iTarget = 16'h0000; iClearFlags = 1'b0;
        modelReset();
        repeat (2) @(posedge Clock);
        #1;
        checkVal("rst_oIP",   32'(oIP),             32'(RV));
        checkVal("rst_depth", 32'(oStackDepth),     32'd0);
        checkVal("rst_empty", 32'(oStackEmpty),     32'd1);
        checkVal("rst_full",  32'(oStackFull),      32'd0);
        checkVal("rst_ovf",   32'(oStackOverflow),  32'd0);
        checkVal("rst_unf",   32'(oStackUnderflow), 32'd0);
        Reset = 1'b1;

        // Plain sequential fetch.
        idle(5);
        // A call at rIP = 5, followed later by the matching return.
        step(1'b1, 1'b0, 1'b1, 1'b0, 16'h0040, 1'b0);
        idle(2);
        step(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0);
        idle(1);
        // Nested calls past the stack capacity, then returns down past empty.
        for (int k = 1; k <= 5; k++) step(1'b1, 1'b0, 1'b1, 1'b0, AW'(k * 256), 1'b0);
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0);
        idle(1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        // Priority between simultaneous requests.
        step(1'b1, 1'b0, 1'b1, 1'b0, 16'h0300, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 16'h0500, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 16'h0600, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0);
        // A stall masks a call. Then check address wrap.
        step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0700, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0800, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 16'hFFFF, 1'b0);
        idle(2);
        // A clear that coincides with an overflow must leave the flag set.
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b1, 1'b0, AW'(16'h1000 + k), 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 16'h2000, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0);
        // Reset asserted mid-nest clears the stack asynchronously.
        step(1'b1, 1'b0, 1'b1, 1'b0, 16'h0A00, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 16'h0B00, 1'b0);
        iEnable = 1'b0; iCall = 1'b0;
        Reset = 1'b0;
        #1;
        checkVal("async_depth", 32'(oStackDepth), 32'd0);
        checkVal("async_empty", 32'(oStackEmpty), 32'd1);
        checkVal("async_oIP",   32'(oIP),         32'(RV));
        modelReset();
        @(posedge Clock);
        #1;
        Reset = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0);
        idle(1);
        // Mixed random traffic.
        for (int k = 0; k < 60; k++) begin
            step(1'($urandom_range(0, 5) != 0), 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0),
                 AW'($urandom), 1'($urandom_range(0, 6) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
